pupil_locator: RTL and testbench

Consumer at the far end of the grayscale pixel stream: takes the per-pixel gray value and camera H/V counters, thresholds dark pixels inside the active window, and accumulates count and coordinate sums over one frame. At frame end it divides the sums to produce the dark-region centroid. The centroid drives the marker overlay and pupil tracking logic. One result per processed frame, published with a single-cycle strobe.

---
 rtl/pupil_pkg.sv | 30 +++
 rtl/pupil_serial_div.sv | 75 +++++++
 rtl/pupil_locator.sv | 194 +++++++++++++++++++
 tb/tb_pupil_locator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pupil_pkg.sv
// Shared types and constants for the pupil locator and its neighbours in the
// pixel pipeline (window bounds are shared with the gray-conversion stage).
package pupil_pkg;

    localparam int CNT_W         = 26;
    localparam int SUM_W         = 39;
    localparam int COORD_W       = 13;
    localparam int GRAY_W        = 10;

    localparam int WIN_H_MIN     = 256;
    localparam int WIN_H_MAX     = 640;
    localparam int DEF_MIN_COUNT = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_DIV_X   = 3'd2,
        ST_DIV_Y   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_e;

    // Truncating average of two coordinates using one extra bit of headroom.
    function automatic logic [COORD_W-1:0] coord_avg(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COORD_W:1];
    endfunction

endpackage

// File: rtl/pupil_serial_div.sv
// Restoring serial divider: one quotient bit per clock, always DIVIDEND_W
// steps from start to done. The first step is taken on the start edge itself,
// so done is visible DIVIDEND_W cycles after start.
module pupil_serial_div
    import pupil_pkg::*;
#(
    parameter int DIVIDEND_W = SUM_W,
    parameter int DIVISOR_W  = CNT_W,
    parameter int QUO_W      = COORD_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [QUO_W-1:0]      quotient_o
);

    localparam int STEP_W = $clog2(DIVIDEND_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEPS = STEP_W'(DIVIDEND_W - 1);

    logic                  busy_q;
    logic                  done_q;
    logic [STEP_W-1:0]     steps_q;
    logic [DIVISOR_W-1:0]  rem_q, rem_d, dsr_q, src_rem, src_dsr, diff;
    logic [DIVIDEND_W-1:0] quo_q, quo_d, src_quo;
    logic [DIVISOR_W:0]    shifted;

    // One restoring step; on start the operands come straight from the ports.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_dsr = start_i ? divisor_i : dsr_q;
        shifted = {src_rem, src_quo[DIVIDEND_W-1]};
        diff    = shifted[DIVISOR_W-1:0] - src_dsr;
        rem_d   = shifted[DIVISOR_W-1:0];
        quo_d   = {src_quo[DIVIDEND_W-2:0], 1'b0};
        if (shifted >= {1'b0, src_dsr}) begin
            rem_d    = diff;
            quo_d[0] = 1'b1;
        end
    end

    // Step sequencing; done stays high until the next start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            steps_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            steps_q <= LAST_STEPS;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= divisor_i;
        end else if (busy_q) begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            steps_q <= steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q[QUO_W-1:0];

endmodule

// File: rtl/pupil_locator.sv
// Dark-region centroid finder: thresholds pixels inside the horizontal window,
// accumulates count and coordinate sums per frame, divides at frame end and
// publishes the centroid with a one-cycle strobe.
// Optional build macro PUPIL_SMOOTH_EN averages each new detection with the
// previous published centroid.
module pupil_locator
    import pupil_pkg::*;
#(
    parameter int H_MIN     = WIN_H_MIN,
    parameter int H_MAX     = WIN_H_MAX,
    parameter int MIN_COUNT = DEF_MIN_COUNT
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [GRAY_W-1:0]  iGRAY,
    input  logic [COORD_W-1:0] iH_Cont,
    input  logic [COORD_W-1:0] iV_Cont,
    input  logic [GRAY_W-1:0]  iTHRESH,
    output logic [COORD_W-1:0] oCX,
    output logic [COORD_W-1:0] oCY,
    output logic               oFOUND,
    output logic               oVALID,
    output logic               oBUSY
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_ACCUM   = ST_ACCUM;
    localparam logic [2:0] S_DIV_X   = ST_DIV_X;
    localparam logic [2:0] S_DIV_Y   = ST_DIV_Y;
    localparam logic [2:0] S_PUBLISH = ST_PUBLISH;

    localparam logic [COORD_W-1:0] H_LO    = COORD_W'(H_MIN);
    localparam logic [COORD_W-1:0] H_HI    = COORD_W'(H_MAX);
    localparam logic [CNT_W-1:0]   CNT_MIN = CNT_W'(MIN_COUNT);

    logic [2:0]         state_q, state_d;
    logic               fval_q;
    logic               rise;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sumx_q, sumx_d, sumy_q, sumy_d;
    logic [GRAY_W-1:0]  thr_q, thr_d;
    logic [COORD_W-1:0] qx_q, qx_d, cx_q, cx_d, cy_q, cy_d;
    logic               found_q, found_d, valid_q, valid_d;
    logic               pix_hit, div_start, div_done;
    logic [SUM_W-1:0]   div_dividend;
    logic [COORD_W-1:0] div_quo;
`ifdef PUPIL_SMOOTH_EN
    logic               seen_q, seen_d;
`endif

    assign rise    = iFVAL & ~fval_q;
    assign pix_hit = iFVAL && iDVAL && (iH_Cont > H_LO) && (iH_Cont < H_HI)
                     && (iGRAY < thr_q);

    // X is divided first, so the dividend switches to Y once DIV_X completes.
    assign div_dividend = (state_q == S_DIV_X) ? sumy_q : sumx_q;

    pupil_serial_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUO_W      (COORD_W)
    ) u_div (
        .clk_i      (iCLK),
        .rst_ni     (iRST),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (cnt_q),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Frame sequencing, accumulation and result publication.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sumx_d    = sumx_q;
        sumy_d    = sumy_q;
        thr_d     = thr_q;
        qx_d      = qx_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        found_d   = found_q;
        valid_d   = 1'b0;
        div_start = 1'b0;
`ifdef PUPIL_SMOOTH_EN
        seen_d    = seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    sumx_d  = '0;
                    sumy_d  = '0;
                    thr_d   = iTHRESH;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!iFVAL) begin
                    if (cnt_q >= CNT_MIN) begin
                        div_start = 1'b1;
                        state_d   = S_DIV_X;
                    end else begin
                        found_d = 1'b0;
                        valid_d = 1'b1;
                        state_d = S_PUBLISH;
                    end
                end else if (pix_hit) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    sumx_d = sumx_q + SUM_W'(iH_Cont);
                    sumy_d = sumy_q + SUM_W'(iV_Cont);
                end
            end
            S_DIV_X: begin
                if (div_done) begin
                    qx_d      = div_quo;
                    div_start = 1'b1;
                    state_d   = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                if (div_done) begin
`ifdef PUPIL_SMOOTH_EN
                    if (seen_q) begin
                        cx_d = coord_avg(cx_q, qx_q);
                        cy_d = coord_avg(cy_q, div_quo);
                    end else begin
                        cx_d = qx_q;
                        cy_d = div_quo;
                    end
                    seen_d = 1'b1;
`else
                    cx_d = qx_q;
                    cy_d = div_quo;
`endif
                    found_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_PUBLISH;
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame or divide in flight.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            fval_q  <= 1'b0;
            cnt_q   <= '0;
            sumx_q  <= '0;
            sumy_q  <= '0;
            thr_q   <= '0;
            qx_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            found_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fval_q  <= iFVAL;
            cnt_q   <= cnt_d;
            sumx_q  <= sumx_d;
            sumy_q  <= sumy_d;
            thr_q   <= thr_d;
            qx_q    <= qx_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            found_q <= found_d;
            valid_q <= valid_d;
        end
    end

`ifdef PUPIL_SMOOTH_EN
    // Remembers whether a detection has been published since reset.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
`endif

    assign oCX    = cx_q;
    assign oCY    = cy_q;
    assign oFOUND = found_q;
    assign oVALID = valid_q;
    assign oBUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pupil_locator.sv
// Directed testbench for pupil_locator: small synthetic frames with a dark
// 8x8 block inside a 20x14 scanned region, hand-computed centroids.
module tb_pupil_locator;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFVAL;
    logic        iDVAL;
    logic [9:0]  iGRAY;
    logic [12:0] iH_Cont;
    logic [12:0] iV_Cont;
    logic [9:0]  iTHRESH;
    logic [12:0] oCX;
    logic [12:0] oCY;
    logic        oFOUND;
    logic        oVALID;
    logic        oBUSY;

    int testsRun   = 0;
    int failCount  = 0;
    int validCount = 0;
    int vcBefore;
    int expCX, expCY, expFound;
    bit havePrev;

    always #5 iCLK = ~iCLK;

    pupil_locator dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iFVAL   (iFVAL),
        .iDVAL   (iDVAL),
        .iGRAY   (iGRAY),
        .iH_Cont (iH_Cont),
        .iV_Cont (iV_Cont),
        .iTHRESH (iTHRESH),
        .oCX     (oCX),
        .oCY     (oCY),
        .oFOUND  (oFOUND),
        .oVALID  (oVALID),
        .oBUSY   (oBUSY)
    );

    // Counts every published strobe cycle while out of reset.
    always @(negedge iCLK) begin
        if (iRST && oVALID) validCount <= validCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        expCX    = 0;
        expCY    = 0;
        expFound = 0;
        havePrev = 1'b0;
    endtask

    task automatic modelDetect(input int qx, input int qy);
`ifdef PUPIL_SMOOTH_EN
        if (havePrev) begin
            expCX = (expCX + qx) / 2;
            expCY = (expCY + qy) / 2;
        end else begin
            expCX = qx;
            expCY = qy;
        end
`else
        expCX = qx;
        expCY = qy;
`endif
        havePrev = 1'b1;
        expFound = 1;
    endtask

    task automatic modelNoDetect();
        expFound = 0;
    endtask

    // One frame: region H bx-4..bx+15, V by-2..by+11, dark block at bx..bx+7 / by..by+7.
    task automatic applyStimulus(input int bx, input int by, input int thr,
                                 input bit hole, input bit extras, input bit thrChange);
        int edgeH[3];
        edgeH = '{256, 640, 200};
        iTHRESH = 10'(thr);
        iFVAL   = 1'b1;
        iDVAL   = 1'b0;
        repeat (3) @(negedge iCLK);
        for (int v = by - 2; v <= by + 11; v++) begin
            for (int h = bx - 4; h <= bx + 15; h++) begin
                iDVAL   = 1'b1;
                iH_Cont = 13'(h);
                iV_Cont = 13'(v);
                iGRAY   = (h >= bx && h < bx + 8 && v >= by && v < by + 8) ? 10'd50 : 10'd900;
                if (hole && h == bx && v == by) iGRAY = 10'd900;
                if (thrChange && v == by + 4 && h == bx - 4) iTHRESH = 10'd1023;
                @(negedge iCLK);
            end
        end
        if (extras) begin
            for (int i = 0; i < 3; i++) begin
                iDVAL   = 1'b1;
                iH_Cont = 13'(edgeH[i]);
                iV_Cont = 13'(by);
                iGRAY   = 10'd50;
                @(negedge iCLK);
            end
        end
        iDVAL = 1'b0;
        repeat (2) @(negedge iCLK);
        iFVAL = 1'b0;
    endtask

    // Latency counted in cycles after the edge that samples iFVAL low.
    task automatic waitValid(input string tag, input int expLat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge iCLK);
            if (oVALID === 1'b1) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, "_lat"},   lat,    expLat);
        checkOutput({tag, "_cx"},    oCX,    expCX);
        checkOutput({tag, "_cy"},    oCY,    expCY);
        checkOutput({tag, "_found"}, oFOUND, expFound);
        @(negedge iCLK);
        checkOutput({tag, "_pulse"}, oVALID, 0);
        checkOutput({tag, "_busy"},  oBUSY,  0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        iRST    = 1'b0;
        iFVAL   = 1'b0;
        iDVAL   = 1'b0;
        iGRAY   = '0;
        iH_Cont = '0;
        iV_Cont = '0;
        iTHRESH = '0;
        modelReset();
        repeat (3) @(negedge iCLK);
        checkOutput("rst_cx",    oCX,    0);
        checkOutput("rst_cy",    oCY,    0);
        checkOutput("rst_found", oFOUND, 0);
        checkOutput("rst_valid", oVALID, 0);
        checkOutput("rst_busy",  oBUSY,  0);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);

        applyStimulus(300, 100, 128, 0, 0, 0);
        modelDetect(303, 103);
        waitValid("blk1", 79);

        applyStimulus(398, 198, 128, 0, 0, 0);
        modelDetect(401, 201);
        waitValid("blk2", 79);

        applyStimulus(300, 100, 128, 1, 0, 0);
        modelNoDetect();
        waitValid("hole", 1);

        applyStimulus(300, 100, 128, 0, 1, 0);
        modelDetect(303, 103);
        waitValid("edges", 79);

        applyStimulus(398, 198, 128, 0, 0, 1);
        modelDetect(401, 201);
        waitValid("thrmid", 79);

        applyStimulus(398, 198, 1023, 0, 0, 0);
        modelDetect(403, 202);
        waitValid("thrnew", 79);

        applyStimulus(300, 100, 128, 0, 0, 0);
        repeat (10) @(negedge iCLK);
        checkOutput("abort_busy_pre", oBUSY, 1);
        vcBefore = validCount;
        iRST = 1'b0;
        modelReset();
        @(negedge iCLK);
        checkOutput("abort_cx",    oCX,    0);
        checkOutput("abort_cy",    oCY,    0);
        checkOutput("abort_found", oFOUND, 0);
        checkOutput("abort_valid", oVALID, 0);
        checkOutput("abort_busy",  oBUSY,  0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        repeat (100) @(negedge iCLK);
        checkOutput("abort_novalid", validCount, vcBefore);

        applyStimulus(398, 198, 128, 0, 0, 0);
        modelDetect(401, 201);
        waitValid("afterrst", 79);

        applyStimulus(300, 100, 128, 0, 0, 0);
        modelDetect(303, 103);
        vcBefore = validCount;
        repeat (50) @(negedge iCLK);
        checkOutput("ovl_busy", oBUSY, 1);
        applyStimulus(398, 198, 1023, 0, 0, 0);
        repeat (100) @(negedge iCLK);
        checkOutput("ovl_count", validCount - vcBefore, 1);
        checkOutput("ovl_cx",    oCX,    expCX);
        checkOutput("ovl_cy",    oCY,    expCY);
        checkOutput("ovl_found", oFOUND, expFound);

        applyStimulus(300, 100, 1023, 0, 0, 0);
        modelDetect(305, 104);
        waitValid("ovl_next", 79);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
